// File: rtl/arf_pkg.sv
// Shared definitions for the ARF dataflow scheduler: op kinds, value-file slots
// and the constant 28-entry op table (issue order = topological order).
package arf_pkg;

    typedef enum logic {OP_MUL, OP_ADD} op_kind_e;
    typedef enum logic {POS, NEG} coef_sel_e;

    localparam int NSLOT  = 36;
    localparam int SLOT_W = 6;
    typedef logic [SLOT_W-1:0] slot_t;

    // Slots 0..7 hold the inputs, slots 8..35 the results of ops 1..28.
    localparam slot_t V0 = 6'd0, V1 = 6'd1, V2 = 6'd2, V3 = 6'd3;
    localparam slot_t V4 = 6'd4, V5 = 6'd5, V6 = 6'd6, V7 = 6'd7;
    localparam slot_t R1  = 6'd8,  R2  = 6'd9,  R3  = 6'd10, R4  = 6'd11;
    localparam slot_t R5  = 6'd12, R6  = 6'd13, R7  = 6'd14, R8  = 6'd15;
    localparam slot_t R9  = 6'd16, R10 = 6'd17, R11 = 6'd18, R12 = 6'd19;
    localparam slot_t R13 = 6'd20, R14 = 6'd21, R15 = 6'd22, R16 = 6'd23;
    localparam slot_t R17 = 6'd24, R18 = 6'd25, R19 = 6'd26, R20 = 6'd27;
    localparam slot_t R21 = 6'd28, R22 = 6'd29, R23 = 6'd30, R24 = 6'd31;
    localparam slot_t R25 = 6'd32, R26 = 6'd33, R27 = 6'd34, R28 = 6'd35;
    localparam slot_t ZERO = 6'd63;

    typedef struct packed {
        op_kind_e  kind;
        slot_t     src_a;
        slot_t     src_b;
        coef_sel_e coef_sel;
    } op_t;

    // Multiplies use src_a times the selected coefficient; adds ignore coef_sel.
    localparam op_t ARF_OPS [1:28] = '{
        '{OP_MUL, V0,  ZERO, POS}, '{OP_MUL, V1,  ZERO, POS},
        '{OP_MUL, V2,  ZERO, POS}, '{OP_MUL, V3,  ZERO, POS},
        '{OP_MUL, V4,  ZERO, POS}, '{OP_MUL, V5,  ZERO, POS},
        '{OP_MUL, V6,  ZERO, POS}, '{OP_MUL, V7,  ZERO, POS},
        '{OP_ADD, R1,  R2,   POS}, '{OP_ADD, R3,  R4,   POS},
        '{OP_ADD, R5,  R6,   POS}, '{OP_ADD, R7,  R8,   POS},
        '{OP_ADD, R10, ZERO, POS}, '{OP_ADD, R11, ZERO, POS},
        '{OP_MUL, R13, ZERO, POS}, '{OP_MUL, R14, ZERO, POS},
        '{OP_MUL, R13, ZERO, POS}, '{OP_MUL, R14, ZERO, POS},
        '{OP_ADD, R15, R16,  POS}, '{OP_ADD, R17, R18,  POS},
        '{OP_MUL, R19, ZERO, NEG}, '{OP_MUL, R20, ZERO, NEG},
        '{OP_MUL, R19, ZERO, NEG}, '{OP_MUL, R20, ZERO, POS},
        '{OP_ADD, R21, R22,  POS}, '{OP_ADD, R23, R24,  POS},
        '{OP_ADD, R9,  R25,  POS}, '{OP_ADD, R12, R26,  POS}
    };

    function automatic slot_t dst_slot(input logic [4:0] k);
        return slot_t'(k) + slot_t'(7);
    endfunction

endpackage

// File: rtl/arf_mul_pipe.sv
// Fully pipelined W-bit multiplier, MUL_LAT stages deep, carrying a valid bit
// and destination slot tag alongside each product.
module arf_mul_pipe import arf_pkg::*; #(
    parameter int W       = 16,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  slot_t        in_tag,
    output logic         out_vld,
    output logic [W-1:0] out_p,
    output slot_t        out_tag,
    output logic         busy
);

    logic [MUL_LAT:1]         vld_pipe;
    slot_t                    tag_pipe [MUL_LAT:1];
    logic [MUL_LAT:1][W-1:0]  p_pipe;
    logic [W-1:0]             prod;

    assign prod = in_a * in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int s = 1; s <= MUL_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            for (int s = MUL_LAT; s > 1; s--) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
            vld_pipe[1] <= in_vld;
            tag_pipe[1] <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = MUL_LAT; s > 1; s--) p_pipe[s] <= p_pipe[s-1];
        p_pipe[1] <= prod;
    end

    assign out_vld = vld_pipe[MUL_LAT];
    assign out_p   = p_pipe[MUL_LAT];
    assign out_tag = tag_pipe[MUL_LAT];
    assign busy    = |vld_pipe;

endmodule

// File: rtl/arf_sched_ctrl.sv
// In-order scoreboarded scheduler for the 28-op ARF graph on one multiplier and
// one adder. Optional ARF_SCHED_PERF_EN adds cycles_o/stalls_o counters.
module arf_sched_ctrl import arf_pkg::*; #(
    parameter int W       = 16,
    parameter int MUL_LAT = 2,
    parameter int COEF    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [8*W-1:0] x_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [W-1:0]   y0_o,
    output logic [W-1:0]   y1_o
`ifdef ARF_SCHED_PERF_EN
    ,
    output logic [15:0]    cycles_o,
    output logic [15:0]    stalls_o
`endif
);

    localparam logic [W-1:0] C_POS = COEF[W-1:0];
    localparam logic [W-1:0] C_NEG = {W{1'b0}} - C_POS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state;
    logic [4:0]       ptr;
    logic [NSLOT-1:0] vld;
    logic [W-1:0]     val [NSLOT];

    op_t          cur;
    logic         src_ok, issue, in_flight;
    logic [W-1:0] opa, opb, coef;
    slot_t        dst;

    logic         mul_vld, mul_busy;
    logic [W-1:0] mul_p;
    slot_t        mul_tag;
    logic         add_vld;
    logic [W-1:0] add_res;
    slot_t        add_tag;

    // Results become visible to issue only from the scoreboard, i.e. the cycle after write-back.
    always_comb begin
        cur = ARF_OPS[1];
        if (ptr >= 5'd1 && ptr <= 5'd28) cur = ARF_OPS[ptr];
        opa    = val[cur.src_a];
        opb    = (cur.src_b == ZERO) ? '0 : val[cur.src_b];
        coef   = (cur.coef_sel == NEG) ? C_NEG : C_POS;
        src_ok = vld[cur.src_a] && ((cur.src_b == ZERO) || vld[cur.src_b]);
        issue  = (state == RUN) && (ptr <= 5'd28) && src_ok;
        dst    = dst_slot(ptr);
    end

    assign in_flight = mul_busy | add_vld;

    arf_mul_pipe #(.W(W), .MUL_LAT(MUL_LAT)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (issue && cur.kind == OP_MUL),
        .in_a    (opa),
        .in_b    (coef),
        .in_tag  (dst),
        .out_vld (mul_vld),
        .out_p   (mul_p),
        .out_tag (mul_tag),
        .busy    (mul_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_vld <= 1'b0;
            add_tag <= '0;
            add_res <= '0;
        end else begin
            add_vld <= issue && cur.kind == OP_ADD;
            add_tag <= dst;
            add_res <= opa + opb;
        end
    end

    // Two write ports: multiplier and adder write-backs can land together.
    always_ff @(posedge clk) begin
        if (state == IDLE && start_i)
            for (int k = 0; k < 8; k++) val[k] <= x_i[k*W +: W];
        if (mul_vld) val[mul_tag] <= mul_p;
        if (add_vld) val[add_tag] <= add_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 5'd1;
            vld    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            y0_o   <= '0;
            y1_o   <= '0;
        end else begin
            done_o <= 1'b0;
            if (mul_vld) vld[mul_tag] <= 1'b1;
            if (add_vld) vld[add_tag] <= 1'b1;
            case (state)
                IDLE: if (start_i) begin
                    vld    <= NSLOT'(8'hFF);
                    ptr    <= 5'd1;
                    busy_o <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    if (issue) ptr <= ptr + 5'd1;
                    if (ptr > 5'd28 && !in_flight) state <= DONE;
                end
                DONE: begin
                    y0_o   <= val[R27];
                    y1_o   <= val[R28];
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARF_SCHED_PERF_EN
    logic [15:0] cyc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt  <= '0;
            cycles_o <= '0;
            stalls_o <= '0;
        end else if (state == IDLE) begin
            if (start_i) begin
                cyc_cnt  <= 16'd1;
                stalls_o <= '0;
            end
        end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
            if (state == RUN && !issue) stalls_o <= stalls_o + 16'd1;
            if (state == DONE) cycles_o <= cyc_cnt;
        end
    end
`endif

endmodule
